wb_stage: RTL and testbench

Dual-lane write-back stage that sits directly downstream of the memory stage. It accepts one retiring bundle of up to two lanes per handshake and holds any bundle containing a load until the memory stage reports `mem_ok`. It then performs a single registered commit to both register-file write ports, resolves same-destination conflicts between lanes, and maintains a retired-instruction counter.

---
 rtl/wb_stage_if.sv | 52 +++++
 rtl/wb_stage.sv | 145 ++++++++++++++
 tb/tb_wb_stage.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Write-back stage bus: retiring bundle from the memory stage, load completion,
// register-file write ports and retire trace.
interface wb_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             l1_valid;
  logic             l2_valid;
  logic [XLEN-1:0]  l1_pc;
  logic [XLEN-1:0]  l2_pc;
  logic [RADDR-1:0] l1_rd;
  logic [RADDR-1:0] l2_rd;
  logic             l1_we;
  logic             l2_we;
  logic             l1_is_load;
  logic             l2_is_load;
  logic [XLEN-1:0]  l1_result;
  logic [XLEN-1:0]  l2_result;
  logic             mem_ok;
  logic [XLEN-1:0]  mem_result;
  logic             rf_we1;
  logic             rf_we2;
  logic [RADDR-1:0] rf_waddr1;
  logic [RADDR-1:0] rf_waddr2;
  logic [XLEN-1:0]  rf_wdata1;
  logic [XLEN-1:0]  rf_wdata2;
  logic             commit_valid;
  logic [XLEN-1:0]  commit_pc1;
  logic [XLEN-1:0]  commit_pc2;
  logic [1:0]       commit_n;
  logic             load_pending;
  logic [31:0]      instret;

  // Upstream/environment side
  modport master (
    output flush, in_valid, l1_valid, l2_valid, l1_pc, l2_pc, l1_rd, l2_rd, l1_we, l2_we,
           l1_is_load, l2_is_load, l1_result, l2_result, mem_ok, mem_result,
    input  in_ready, rf_we1, rf_we2, rf_waddr1, rf_waddr2, rf_wdata1, rf_wdata2,
           commit_valid, commit_pc1, commit_pc2, commit_n, load_pending, instret
  );

  // Write-back stage side
  modport slave (
    input  flush, in_valid, l1_valid, l2_valid, l1_pc, l2_pc, l1_rd, l2_rd, l1_we, l2_we,
           l1_is_load, l2_is_load, l1_result, l2_result, mem_ok, mem_result,
    output in_ready, rf_we1, rf_we2, rf_waddr1, rf_waddr2, rf_wdata1, rf_wdata2,
           commit_valid, commit_pc1, commit_pc2, commit_n, load_pending, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Dual-lane write-back stage. Commits a bundle of up to two lanes to both
// register-file write ports in one registered cycle, holding load bundles
// until the memory stage reports completion.
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic      clk,
  input  logic      reset,
  wb_stage_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [RADDR-1:0] rd;
    logic             we;
    logic             is_load;
    logic [XLEN-1:0]  result;
  } lane_t;

  state_e      state_q;
  lane_t       b1_q, b2_q;
  lane_t       in1, in2, cur1, cur2;
  logic        accept, in_has_load, do_commit;
  logic        ld1, ld2, we1, we2;
  logic [1:0]  n_lanes;

  logic             rf_we1_q, rf_we2_q, commit_valid_q;
  logic [RADDR-1:0] rf_waddr1_q, rf_waddr2_q;
  logic [XLEN-1:0]  rf_wdata1_q, rf_wdata2_q, commit_pc1_q, commit_pc2_q;
  logic [1:0]       commit_n_q;
  logic [31:0]      instret_q;

  // Lane decode: pick the bundle being committed (live inputs in IDLE, latched in WAIT)
  always_comb begin
    in1.valid   = bus.l1_valid;
    in1.pc      = bus.l1_pc;
    in1.rd      = bus.l1_rd;
    in1.we      = bus.l1_we;
    in1.is_load = bus.l1_is_load;
    in1.result  = bus.l1_result;
    in2.valid   = bus.l2_valid;
    in2.pc      = bus.l2_pc;
    in2.rd      = bus.l2_rd;
    in2.we      = bus.l2_we;
    in2.is_load = bus.l2_is_load;
    in2.result  = bus.l2_result;

    accept      = bus.in_valid & (state_q == StIdle) & ~bus.flush;
    in_has_load = (in1.valid & in1.is_load) | (in2.valid & in2.is_load);

    cur1 = (state_q == StIdle) ? in1 : b1_q;
    cur2 = (state_q == StIdle) ? in2 : b2_q;

    if (state_q == StIdle) begin
      do_commit = accept & (~in_has_load | bus.mem_ok);
    end else begin
      do_commit = ~bus.flush & bus.mem_ok;
    end

    // Lane1 owns mem_result when both lanes claim to be loads
    ld1 = cur1.valid & cur1.is_load;
    ld2 = cur2.valid & cur2.is_load & ~ld1;

    we1 = cur1.valid & cur1.we & (cur1.rd != '0);
    we2 = cur2.valid & cur2.we & (cur2.rd != '0);
    // Younger lane wins a same-destination conflict
    if (we1 && we2 && (cur1.rd == cur2.rd)) begin
      we1 = 1'b0;
    end

    n_lanes = {1'b0, cur1.valid} + {1'b0, cur2.valid};
  end

  // FSM plus registered commit outputs and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      b1_q           <= '0;
      b2_q           <= '0;
      rf_we1_q       <= 1'b0;
      rf_we2_q       <= 1'b0;
      rf_waddr1_q    <= '0;
      rf_waddr2_q    <= '0;
      rf_wdata1_q    <= '0;
      rf_wdata2_q    <= '0;
      commit_valid_q <= 1'b0;
      commit_pc1_q   <= '0;
      commit_pc2_q   <= '0;
      commit_n_q     <= '0;
      instret_q      <= '0;
    end else begin
      rf_we1_q       <= 1'b0;
      rf_we2_q       <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_n_q     <= '0;
      if (do_commit) begin
        rf_we1_q       <= we1;
        rf_we2_q       <= we2;
        rf_waddr1_q    <= cur1.rd;
        rf_waddr2_q    <= cur2.rd;
        rf_wdata1_q    <= ld1 ? bus.mem_result : cur1.result;
        rf_wdata2_q    <= ld2 ? bus.mem_result : cur2.result;
        commit_valid_q <= (n_lanes != 2'd0);
        commit_pc1_q   <= cur1.pc;
        commit_pc2_q   <= cur2.pc;
        commit_n_q     <= n_lanes;
        instret_q      <= instret_q + 32'(n_lanes);
      end
      unique case (state_q)
        StIdle: begin
          if (accept && in_has_load && !bus.mem_ok) begin
            state_q <= StWait;
            b1_q    <= in1;
            b2_q    <= in2;
          end
        end
        StWait: begin
          if (bus.flush || bus.mem_ok) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == StIdle);
  assign bus.load_pending = (state_q == StWait);
  assign bus.rf_we1       = rf_we1_q;
  assign bus.rf_we2       = rf_we2_q;
  assign bus.rf_waddr1    = rf_waddr1_q;
  assign bus.rf_waddr2    = rf_waddr2_q;
  assign bus.rf_wdata1    = rf_wdata1_q;
  assign bus.rf_wdata2    = rf_wdata2_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_pc1   = commit_pc1_q;
  assign bus.commit_pc2   = commit_pc2_q;
  assign bus.commit_n     = commit_n_q;
  assign bus.instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: transaction-level model of pending bundles and commits,
// compared every cycle, plus hand-computed literal expectations.
module tb_wb_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [31:0] res;
  } lane_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  wb_stage_if bus ();

  wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] pc_ctr = 32'h100;
  logic preload_req = 1'b0;

  // Model state
  logic        m_pend    = 1'b0;
  lane_t       m_pa      = '0;
  lane_t       m_pb      = '0;
  logic        e_we1     = 1'b0;
  logic        e_we2     = 1'b0;
  logic [4:0]  e_waddr1  = '0;
  logic [4:0]  e_waddr2  = '0;
  logic [31:0] e_wdata1  = '0;
  logic [31:0] e_wdata2  = '0;
  logic [31:0] e_pc1     = '0;
  logic [31:0] e_pc2     = '0;
  logic        e_cv      = 1'b0;
  logic [1:0]  e_n       = '0;
  logic [31:0] m_instret = '0;

  function automatic lane_t cap1();
    lane_t l;
    l = '{v: bus.l1_valid, pc: bus.l1_pc, rd: bus.l1_rd, we: bus.l1_we,
          ld: bus.l1_is_load, res: bus.l1_result};
    return l;
  endfunction

  function automatic lane_t cap2();
    lane_t l;
    l = '{v: bus.l2_valid, pc: bus.l2_pc, rd: bus.l2_rd, we: bus.l2_we,
          ld: bus.l2_is_load, res: bus.l2_result};
    return l;
  endfunction

  // Expected register writes and trace for retiring bundle (a older, b younger)
  task automatic m_commit(input lane_t a, input lane_t b, input logic [31:0] mr);
    logic wa, wb, mem_a, mem_b;
    int   cnt;
    wa    = a.v && a.we && (a.rd != 0);
    wb    = b.v && b.we && (b.rd != 0);
    if (wa && wb && a.rd == b.rd) wa = 1'b0;
    mem_a = a.v && a.ld;
    mem_b = b.v && b.ld && !mem_a;
    cnt   = (a.v ? 1 : 0) + (b.v ? 1 : 0);
    e_we1    = wa;
    e_we2    = wb;
    e_waddr1 = a.rd;
    e_waddr2 = b.rd;
    e_wdata1 = mem_a ? mr : a.res;
    e_wdata2 = mem_b ? mr : b.res;
    e_pc1    = a.pc;
    e_pc2    = b.pc;
    e_n      = 2'(cnt);
    e_cv     = (cnt != 0);
    m_instret = m_instret + 32'(cnt);
  endtask

  always @(posedge clk or negedge reset) begin
    lane_t a, b;
    if (!reset) begin
      m_pend = 1'b0;
      e_we1 = 1'b0; e_we2 = 1'b0; e_cv = 1'b0; e_n = '0;
      e_waddr1 = '0; e_waddr2 = '0; e_wdata1 = '0; e_wdata2 = '0;
      e_pc1 = '0; e_pc2 = '0;
      m_instret = '0;
    end else begin
      e_we1 = 1'b0; e_we2 = 1'b0; e_cv = 1'b0; e_n = '0;
      if (preload_req) m_instret = 32'hFFFF_FFFF;
      if (!m_pend) begin
        if (bus.in_valid && !bus.flush) begin
          a = cap1();
          b = cap2();
          if (!((a.v && a.ld) || (b.v && b.ld)) || bus.mem_ok) m_commit(a, b, bus.mem_result);
          else begin
            m_pend = 1'b1;
            m_pa   = a;
            m_pb   = b;
          end
        end
      end else if (bus.flush) begin
        m_pend = 1'b0;
      end else if (bus.mem_ok) begin
        m_commit(m_pa, m_pb, bus.mem_result);
        m_pend = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_cycle();
    chk("in_ready", 32'(bus.in_ready), 32'(!m_pend));
    chk("load_pending", 32'(bus.load_pending), 32'(m_pend));
    chk("rf_we1", 32'(bus.rf_we1), 32'(e_we1));
    chk("rf_we2", 32'(bus.rf_we2), 32'(e_we2));
    chk("commit_valid", 32'(bus.commit_valid), 32'(e_cv));
    chk("commit_n", 32'(bus.commit_n), 32'(e_n));
    chk("instret", bus.instret, m_instret);
    if (e_we1) begin
      chk("rf_waddr1", 32'(bus.rf_waddr1), 32'(e_waddr1));
      chk("rf_wdata1", bus.rf_wdata1, e_wdata1);
    end
    if (e_we2) begin
      chk("rf_waddr2", 32'(bus.rf_waddr2), 32'(e_waddr2));
      chk("rf_wdata2", bus.rf_wdata2, e_wdata2);
    end
    if (e_cv) begin
      chk("commit_pc1", bus.commit_pc1, e_pc1);
      chk("commit_pc2", bus.commit_pc2, e_pc2);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    check_cycle();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic bundle(input logic v1, input logic [4:0] rd1, input logic we1, input logic ld1,
                        input logic [31:0] r1, input logic v2, input logic [4:0] rd2,
                        input logic we2, input logic ld2, input logic [31:0] r2);
    bus.in_valid   = 1'b1;
    bus.l1_valid   = v1;  bus.l1_rd = rd1; bus.l1_we = we1; bus.l1_is_load = ld1;
    bus.l1_result  = r1;  bus.l1_pc = pc_ctr;
    bus.l2_valid   = v2;  bus.l2_rd = rd2; bus.l2_we = we2; bus.l2_is_load = ld2;
    bus.l2_result  = r2;  bus.l2_pc = pc_ctr + 32'd4;
    pc_ctr         = pc_ctr + 32'd8;
  endtask

  initial begin
    idle();
    bus.mem_ok = 1'b0; bus.mem_result = '0;
    bus.l1_valid = 0; bus.l1_rd = 0; bus.l1_we = 0; bus.l1_is_load = 0; bus.l1_result = 0;
    bus.l1_pc = 0;
    bus.l2_valid = 0; bus.l2_rd = 0; bus.l2_we = 0; bus.l2_is_load = 0; bus.l2_result = 0;
    bus.l2_pc = 0;

    // Reset values
    step(); step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_waddr1", 32'(bus.rf_waddr1), 32'd0);
    chk("rst_wdata2", bus.rf_wdata2, 32'd0);
    chk("rst_pc1", bus.commit_pc1, 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    reset = 1'b1;
    step();

    // Simple two-lane bundle
    bundle(1, 5'd3, 1, 0, 32'h11, 1, 5'd4, 1, 0, 32'h22);
    step(); idle();
    chk("t1_we1", 32'(bus.rf_we1), 32'd1);
    chk("t1_wdata1", bus.rf_wdata1, 32'h11);
    chk("t1_we2", 32'(bus.rf_we2), 32'd1);
    chk("t1_wdata2", bus.rf_wdata2, 32'h22);
    chk("t1_n", 32'(bus.commit_n), 32'd2);
    chk("t1_pc1", bus.commit_pc1, 32'h100);
    chk("t1_instret", bus.instret, 32'd2);
    chk("t1_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Back-to-back bundles, no bubbles
    for (int i = 0; i < 4; i++) begin
      bundle(1, 5'(8 + i), 1, 0, 32'(i * 16 + 1), 1, 5'(16 + i), 1, 0, 32'(i * 16 + 2));
      step();
      chk("b2b_cv", 32'(bus.commit_valid), 32'd1);
    end
    idle(); step();
    chk("b2b_instret", bus.instret, 32'd10);

    // Load stall: mem_ok low for 3 cycles, lane inputs scrambled while waiting
    bundle(1, 5'd5, 1, 1, 32'h0BAD, 1, 5'd6, 1, 0, 32'h66);
    bus.mem_ok = 1'b0;
    step(); idle();
    bus.l1_rd = 5'd9; bus.l1_result = 32'h1; bus.l2_rd = 5'd10; bus.l2_result = 32'h2;
    chk("stall_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_pending", 32'(bus.load_pending), 32'd1);
    step(); step();
    bus.mem_ok = 1'b1; bus.mem_result = 32'hDEAD_BEEF;
    step(); bus.mem_ok = 1'b0;
    chk("ld_waddr1", 32'(bus.rf_waddr1), 32'd5);
    chk("ld_wdata1", bus.rf_wdata1, 32'hDEAD_BEEF);
    chk("ld_wdata2", bus.rf_wdata2, 32'h66);
    chk("ld_pending", 32'(bus.load_pending), 32'd0);
    chk("ld_instret", bus.instret, 32'd12);

    // Both lanes claim load, mem_ok in acceptance cycle
    bundle(1, 5'd9, 1, 1, 32'h99, 1, 5'd10, 1, 1, 32'h1010);
    bus.mem_ok = 1'b1; bus.mem_result = 32'h5555;
    step(); idle(); bus.mem_ok = 1'b0;
    chk("dl_wdata1", bus.rf_wdata1, 32'h5555);
    chk("dl_wdata2", bus.rf_wdata2, 32'h1010);

    // Only lane2 valid and a load
    bundle(0, 5'd11, 1, 1, 32'h0, 1, 5'd12, 1, 1, 32'h0);
    step(); idle(); step();
    bus.mem_ok = 1'b1; bus.mem_result = 32'hCAFE;
    step(); bus.mem_ok = 1'b0;
    chk("l2ld_we1", 32'(bus.rf_we1), 32'd0);
    chk("l2ld_wdata2", bus.rf_wdata2, 32'hCAFE);
    chk("l2ld_n", 32'(bus.commit_n), 32'd1);

    // Same-destination conflict
    bundle(1, 5'd7, 1, 0, 32'hA, 1, 5'd7, 1, 0, 32'hB);
    step(); idle();
    chk("cf_we1", 32'(bus.rf_we1), 32'd0);
    chk("cf_we2", 32'(bus.rf_we2), 32'd1);
    chk("cf_wdata2", bus.rf_wdata2, 32'hB);
    chk("cf_n", 32'(bus.commit_n), 32'd2);

    // x0 destination and non-writing lane still retire
    bundle(1, 5'd0, 1, 0, 32'h5, 1, 5'd13, 0, 0, 32'h6);
    step(); idle();
    chk("x0_we1", 32'(bus.rf_we1), 32'd0);
    chk("x0_cv", 32'(bus.commit_valid), 32'd1);
    chk("x0_n", 32'(bus.commit_n), 32'd2);

    // Empty bundle then single lane
    bundle(0, 5'd1, 1, 0, 32'h1, 0, 5'd2, 1, 0, 32'h2);
    step();
    chk("empty_cv", 32'(bus.commit_valid), 32'd0);
    bundle(1, 5'd14, 1, 0, 32'h77, 0, 5'd2, 1, 0, 32'h2);
    step(); idle();
    chk("single_n", 32'(bus.commit_n), 32'd1);
    chk("single_instret", bus.instret, 32'd20);

    // mem_ok while idle has no effect
    bus.mem_ok = 1'b1;
    step(); bus.mem_ok = 1'b0;

    // Flush in WAIT beats mem_ok
    bundle(1, 5'd15, 1, 1, 32'h0, 0, 5'd0, 0, 0, 32'h0);
    step(); idle(); step();
    bus.flush = 1'b1; bus.mem_ok = 1'b1; bus.mem_result = 32'h4242;
    step(); bus.flush = 1'b0; bus.mem_ok = 1'b0;
    chk("fw_cv", 32'(bus.commit_valid), 32'd0);
    chk("fw_ready", 32'(bus.in_ready), 32'd1);
    chk("fw_instret", bus.instret, 32'd20);
    step();

    // Flush in acceptance cycle drops bundle
    bundle(1, 5'd16, 1, 0, 32'h88, 1, 5'd17, 1, 0, 32'h99);
    bus.flush = 1'b1;
    step(); idle();
    chk("fa_cv", 32'(bus.commit_valid), 32'd0);
    chk("fa_instret", bus.instret, 32'd20);

    // Counter wrap
    force dut.instret_q = 32'hFFFF_FFFF;
    preload_req = 1'b1;
    #1;
    release dut.instret_q;
    bundle(1, 5'd18, 1, 0, 32'h1, 1, 5'd19, 1, 0, 32'h2);
    step(); idle();
    preload_req = 1'b0;
    chk("wrap_instret", bus.instret, 32'd1);

    // Reset asserted mid-WAIT
    bundle(1, 5'd20, 1, 1, 32'h0, 0, 5'd0, 0, 0, 32'h0);
    step(); idle();
    chk("rw_pending", 32'(bus.load_pending), 32'd1);
    bus.mem_ok = 1'b1; bus.mem_result = 32'h1234;
    #1 reset = 1'b0;
    #1;
    check_cycle();
    chk("rw_pending_clr", 32'(bus.load_pending), 32'd0);
    chk("rw_ready", 32'(bus.in_ready), 32'd1);
    chk("rw_instret", bus.instret, 32'd0);
    step();
    reset = 1'b1;
    step(); step();
    chk("rw_no_commit", 32'(bus.commit_valid), 32'd0);
    bus.mem_ok = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
